// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter that shares one memory port
// between the instruction cache (client 0) and the data cache (client 1).
//
// A grant is taken from IDLE and held for a whole burst. It is released once
// the owner has both its request valid and its write-data valid low.
// Read requests that handshake push the owner's ID into a small FIFO. That
// lets in-order memory responses be steered back to the client that issued them.
//
// Ports:
//   clk, reset (async, active-low)
//   cN_req_*      client N request / write-data channels (N = 0 icache, 1 dcache)
//   cN_resp_*     client N read response (data is broadcast, valid is steered)
//   mem_req_*     memory request / write-data channels
//   mem_resp_*    in-order memory read responses
//   resp_err      sticky: a response arrived with no read outstanding
module mem_arbiter #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic [ADDR_BITS-1:0]   c0_req_addr,
    input  logic                   c0_req_rw,
    input  logic                   c0_req_data_valid,
    output logic                   c0_req_data_ready,
    input  logic [DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                   c0_resp_valid,
    output logic [DATA_BITS-1:0]   c0_resp_data,

    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic [ADDR_BITS-1:0]   c1_req_addr,
    input  logic                   c1_req_rw,
    input  logic                   c1_req_data_valid,
    output logic                   c1_req_data_ready,
    input  logic [DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                   c1_resp_valid,
    output logic [DATA_BITS-1:0]   c1_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,

    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic                   resp_err
);

    localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        rr_q, rr_d;          // 1: client 1 wins a tie
    logic [MAX_OUTSTANDING-1:0]  ids_q, ids_d;        // owner ID per outstanding read
    logic [PTR_BITS-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]         count_q, count_d;
    logic                        resp_err_q, resp_err_d;

    logic granted;
    logic sel;          // current owner when granted
    logic own_valid;
    logic own_rw;
    logic own_dvalid;
    logic block;
    logic push;
    logic pop;
    logic fifo_empty;
    logic head;
    logic grant1;

    // Owner channel selection and flow-control terms
    always_comb begin
        granted    = (state_q != IDLE);
        sel        = (state_q == OWN1);
        own_valid  = sel ? c1_req_valid      : c0_req_valid;
        own_rw     = sel ? c1_req_rw         : c0_req_rw;
        own_dvalid = sel ? c1_req_data_valid : c0_req_data_valid;
        // Reads stall when the ID FIFO is full; a pop in the same cycle does not help.
        block      = granted & ~own_rw & (count_q == FULL_COUNT);
        push       = granted & own_valid & ~block & mem_req_ready & ~own_rw;
        fifo_empty = (count_q == '0);
        head       = ids_q[rd_ptr_q];
        pop        = mem_resp_valid & ~fifo_empty;
    end

    // Memory-side and client-side handshake outputs
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        c0_req_ready       = 1'b0;
        c0_req_data_ready  = 1'b0;
        c1_req_ready       = 1'b0;
        c1_req_data_ready  = 1'b0;

        if (granted) begin
            mem_req_valid      = own_valid & ~block;
            mem_req_rw         = own_rw;
            mem_req_data_valid = own_dvalid;
            if (sel) begin
                mem_req_addr      = c1_req_addr;
                mem_req_data_bits = c1_req_data_bits;
                mem_req_data_mask = c1_req_data_mask;
                c1_req_ready      = mem_req_ready & ~block;
                c1_req_data_ready = mem_req_data_ready;
            end else begin
                mem_req_addr      = c0_req_addr;
                mem_req_data_bits = c0_req_data_bits;
                mem_req_data_mask = c0_req_data_mask;
                c0_req_ready      = mem_req_ready & ~block;
                c0_req_data_ready = mem_req_data_ready;
            end
        end
    end

    // Response routing: zero added latency
    always_comb begin
        c0_resp_data  = mem_resp_data;
        c1_resp_data  = mem_resp_data;
        c0_resp_valid = pop & ~head;
        c1_resp_valid = pop & head;
        resp_err      = resp_err_q;
    end

    // Arbitration FSM next state
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (c0_req_valid | c1_req_valid) begin
                    grant1  = c1_req_valid & (~c0_req_valid | rr_q);
                    state_d = grant1 ? OWN1 : OWN0;
                    rr_d    = ~grant1;
                end
            end
            OWN0: begin
                if (~c0_req_valid & ~c0_req_data_valid) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (~c1_req_valid & ~c1_req_data_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-ID FIFO and error flag next state
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ids_d[wr_ptr_q] = sel;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        resp_err_d = resp_err_q | (mem_resp_valid & fifo_empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b1;
            ids_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            ids_q      <= ids_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a directed table for a single icache burst, then
// hand-written multi-cycle sequences, then randomized traffic. Every cycle is
// also compared against a queue-based reference model.
module tb_mem_arbiter;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int MO = 4;
    localparam int MB = DB / 8;

    logic          clk = 1'b0;
    logic          reset;

    logic          c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready;
    logic [AB-1:0] c0_req_addr;
    logic [DB-1:0] c0_req_data_bits;
    logic [MB-1:0] c0_req_data_mask;
    logic          c0_resp_valid;
    logic [DB-1:0] c0_resp_data;

    logic          c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready;
    logic [AB-1:0] c1_req_addr;
    logic [DB-1:0] c1_req_data_bits;
    logic [MB-1:0] c1_req_data_mask;
    logic          c1_resp_valid;
    logic [DB-1:0] c1_resp_data;

    logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [AB-1:0] mem_req_addr;
    logic [DB-1:0] mem_req_data_bits;
    logic [MB-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic          resp_err;

    mem_arbiter #(
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .c0_req_valid      (c0_req_valid),
        .c0_req_ready      (c0_req_ready),
        .c0_req_addr       (c0_req_addr),
        .c0_req_rw         (c0_req_rw),
        .c0_req_data_valid (c0_req_data_valid),
        .c0_req_data_ready (c0_req_data_ready),
        .c0_req_data_bits  (c0_req_data_bits),
        .c0_req_data_mask  (c0_req_data_mask),
        .c0_resp_valid     (c0_resp_valid),
        .c0_resp_data      (c0_resp_data),
        .c1_req_valid      (c1_req_valid),
        .c1_req_ready      (c1_req_ready),
        .c1_req_addr       (c1_req_addr),
        .c1_req_rw         (c1_req_rw),
        .c1_req_data_valid (c1_req_data_valid),
        .c1_req_data_ready (c1_req_data_ready),
        .c1_req_data_bits  (c1_req_data_bits),
        .c1_req_data_mask  (c1_req_data_mask),
        .c1_resp_valid     (c1_resp_valid),
        .c1_resp_data      (c1_resp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_rw        (mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .resp_err          (resp_err)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int peak   = 0;
    int rlog[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 idle, else client index; fav: client that wins a tie.
    int owner;
    int fav;
    int idq[$];
    bit m_err;

    bit            e_mem_v, e_mem_rw, e_mem_dv;
    logic [AB-1:0] e_addr;
    logic [DB-1:0] e_bits;
    logic [MB-1:0] e_mask;
    bit            e_c0_rdy, e_c0_drdy, e_c1_rdy, e_c1_drdy, e_c0_rv, e_c1_rv;

    task automatic model_reset();
        owner = -1;
        fav   = 1;
        idq.delete();
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        bit v, rw, dv, blk;
        e_mem_v = 0; e_mem_rw = 0; e_mem_dv = 0;
        e_addr = '0; e_bits = '0; e_mask = '0;
        e_c0_rdy = 0; e_c0_drdy = 0; e_c1_rdy = 0; e_c1_drdy = 0;
        e_c0_rv = 0; e_c1_rv = 0;
        if (owner >= 0) begin
            if (owner == 0) begin
                v = c0_req_valid; rw = c0_req_rw; dv = c0_req_data_valid;
                e_addr = c0_req_addr; e_bits = c0_req_data_bits; e_mask = c0_req_data_mask;
            end else begin
                v = c1_req_valid; rw = c1_req_rw; dv = c1_req_data_valid;
                e_addr = c1_req_addr; e_bits = c1_req_data_bits; e_mask = c1_req_data_mask;
            end
            blk      = !rw && (idq.size() == MO);
            e_mem_v  = v && !blk;
            e_mem_rw = rw;
            e_mem_dv = dv;
            if (owner == 0) begin
                e_c0_rdy  = mem_req_ready && !blk;
                e_c0_drdy = mem_req_data_ready;
            end else begin
                e_c1_rdy  = mem_req_ready && !blk;
                e_c1_drdy = mem_req_data_ready;
            end
        end
        if (mem_resp_valid && idq.size() > 0) begin
            e_c0_rv = (idq[0] == 0);
            e_c1_rv = (idq[0] == 1);
        end
    endtask

    task automatic model_update();
        bit push;
        int k;
        push = e_mem_v && mem_req_ready && !e_mem_rw;
        if (mem_resp_valid) begin
            if (idq.size() == 0) m_err = 1'b1;
            else void'(idq.pop_front());
        end
        if (push) idq.push_back(owner);
        if (owner < 0) begin
            if (c0_req_valid || c1_req_valid) begin
                if (c0_req_valid && c1_req_valid) k = fav;
                else k = c1_req_valid ? 1 : 0;
                owner = k;
                fav   = 1 - k;
            end
        end else if (owner == 0) begin
            if (!c0_req_valid && !c0_req_data_valid) owner = -1;
        end else begin
            if (!c1_req_valid && !c1_req_data_valid) owner = -1;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        chk1("mem_req_valid", mem_req_valid, e_mem_v);
        chkw("mem_req_addr", 128'(mem_req_addr), 128'(e_addr));
        chk1("mem_req_rw", mem_req_rw, e_mem_rw);
        chk1("mem_req_data_valid", mem_req_data_valid, e_mem_dv);
        chkw("mem_req_data_bits", mem_req_data_bits, e_bits);
        chkw("mem_req_data_mask", 128'(mem_req_data_mask), 128'(e_mask));
        chk1("c0_req_ready", c0_req_ready, e_c0_rdy);
        chk1("c0_req_data_ready", c0_req_data_ready, e_c0_drdy);
        chk1("c1_req_ready", c1_req_ready, e_c1_rdy);
        chk1("c1_req_data_ready", c1_req_data_ready, e_c1_drdy);
        chk1("c0_resp_valid", c0_resp_valid, e_c0_rv);
        chk1("c1_resp_valid", c1_resp_valid, e_c1_rv);
        chkw("c0_resp_data", c0_resp_data, mem_resp_data);
        chkw("c1_resp_data", c1_resp_data, mem_resp_data);
        chk1("resp_err", resp_err, m_err);
        chki("fifo_count", int'(dut.count_q), idq.size());
        if (mem_req_valid && mem_req_ready && !mem_req_rw) hs_cnt++;
        if (c0_resp_valid) rlog.push_back(0);
        if (c1_resp_valid) rlog.push_back(1);
        if (int'(dut.count_q) > peak) peak = int'(dut.count_q);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        c0_req_valid = 0; c0_req_addr = '0; c0_req_rw = 0; c0_req_data_valid = 0;
        c0_req_data_bits = '0; c0_req_data_mask = '0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_rw = 0; c1_req_data_valid = 0;
        c1_req_data_bits = '0; c1_req_data_mask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit            c0_v;
        logic [AB-1:0] c0_addr;
        bit            mem_rv;
        logic [DB-1:0] rdata;
        bit            e_mem_v;
        logic [AB-1:0] e_addr;
        bit            e_c0_rdy;
        bit            e_c0_rv;
        bit            e_c1_rv;
    } vec_t;

    vec_t tbl[7];
    int   exp_route[4];

    initial begin
        int hs_before;
        int due[$];
        int k;

        reset = 1'b0;
        clear_inputs();
        model_reset();

        // Single icache read burst: 4 reads at 0x10..0x13, data returned one cycle later.
        tbl[0] = '{1'b1, 28'h10, 1'b0, 128'h0,  1'b0, 28'h0,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 28'h10, 1'b0, 128'h0,  1'b1, 28'h10, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 28'h11, 1'b1, 128'hD0, 1'b1, 28'h11, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 28'h12, 1'b1, 128'hD1, 1'b1, 28'h12, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 28'h13, 1'b1, 128'hD2, 1'b1, 28'h13, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 28'h0,  1'b1, 128'hD3, 1'b0, 28'h0,  1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 28'h0,  1'b0, 128'h0,  1'b0, 28'h0,  1'b0, 1'b0, 1'b0};
        exp_route = '{1, 1, 0, 0};

        do_reset();
        hs_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            c0_req_valid   = tbl[i].c0_v;
            c0_req_addr    = tbl[i].c0_addr;
            c0_req_rw      = 1'b0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = tbl[i].mem_rv;
            mem_resp_data  = tbl[i].rdata;
            #1;
            chk1("tbl_mem_valid", mem_req_valid, tbl[i].e_mem_v);
            chkw("tbl_mem_addr", 128'(mem_req_addr), 128'(tbl[i].e_addr));
            chk1("tbl_c0_ready", c0_req_ready, tbl[i].e_c0_rdy);
            chk1("tbl_c0_resp_valid", c0_resp_valid, tbl[i].e_c0_rv);
            chk1("tbl_c1_resp_valid", c1_resp_valid, tbl[i].e_c1_rv);
            chkw("tbl_c0_resp_data", c0_resp_data, tbl[i].rdata);
            cycle();
        end
        chki("tbl_handshakes", hs_cnt, 4);

        // Simultaneous requests after reset: grants alternate 1,0,1,0.
        do_reset();
        c0_req_rw = 1'b1; c1_req_rw = 1'b1;
        mem_req_ready = 1'b1;
        c0_req_valid = 1'b1; c1_req_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            k = (r % 2 == 0) ? 1 : 0;
            cycle();
            chk1("rr_grant_c1", c1_req_ready, k == 1);
            chk1("rr_grant_c0", c0_req_ready, k == 0);
            chk1("rr_mem_valid", mem_req_valid, 1'b1);
            cycle();
            if (k == 1) c1_req_valid = 1'b0; else c0_req_valid = 1'b0;
            cycle();
            chk1("rr_release_idle", mem_req_valid, 1'b0);
            if (k == 1) c1_req_valid = 1'b1; else c0_req_valid = 1'b1;
        end
        clear_inputs();
        cycle();
        cycle();

        // Interleaved responses with memory latency 6.
        do_reset();
        rlog.delete();
        peak = 0;
        mem_req_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            c1_req_valid   = (t <= 2);
            c0_req_valid   = (t <= 6);
            c1_req_addr    = 28'(t);
            c0_req_addr    = 28'(t + 100);
            mem_resp_valid = (due.size() > 0 && due[0] == t);
            mem_resp_data  = 128'(t) ^ 128'hABCD_0000;
            if (mem_resp_valid) void'(due.pop_front());
            hs_before = hs_cnt;
            cycle();
            if (hs_cnt != hs_before) due.push_back(t + 6);
        end
        chki("route_count", rlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rlog.size()) chki("route_order", rlog[i], exp_route[i]);
        end
        chki("fifo_peak", peak, 4);

        // FIFO full: 4 reads accepted, then blocked until one response.
        do_reset();
        hs_cnt = 0;
        c0_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            c0_req_addr = 28'(t);
            cycle();
        end
        chki("full_handshakes", hs_cnt, 4);
        chk1("full_blocked", c0_req_ready, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hF00D;
        #1;
        chk1("full_resp_c0", c0_resp_valid, 1'b1);
        cycle();
        mem_resp_valid = 1'b0;
        #1;
        chk1("full_reopen", c0_req_ready, 1'b1);
        cycle();
        chki("full_handshakes_after", hs_cnt, 5);
        chk1("full_blocked_again", c0_req_ready, 1'b0);
        c0_req_valid = 1'b0;
        cycle();
        mem_resp_valid = 1'b1;
        for (int t = 0; t < 4; t++) cycle();
        mem_resp_valid = 1'b0;
        cycle();

        // Dirty writeback: data ready lags request ready by 2 cycles.
        do_reset();
        hs_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            c1_req_valid       = (t <= 4);
            c1_req_rw          = 1'b1;
            c1_req_addr        = 28'(t + 32);
            c1_req_data_valid  = (t <= 6);
            c1_req_data_bits   = 128'(t * 3 + 1);
            c1_req_data_mask   = 16'(t + 1);
            c0_req_valid       = 1'b1;
            c0_req_rw          = 1'b0;
            c0_req_addr        = 28'(t + 64);
            mem_req_ready      = 1'b1;
            mem_req_data_ready = (t >= 3 && t <= 6);
            #1;
            if (t >= 1 && t <= 8) chk1("wb_c0_waits", c0_req_ready, 1'b0);
            if (t == 6) chk1("wb_hold_for_data", c1_req_data_ready, 1'b1);
            if (t == 8) chki("wb_no_push", hs_cnt, 0);
            if (t == 9) chk1("wb_c0_granted", c0_req_ready, 1'b1);
            cycle();
        end

        // Error flag and asynchronous reset mid-burst.
        do_reset();
        mem_resp_valid = 1'b1;
        cycle();
        mem_resp_valid = 1'b0;
        cycle();
        cycle();
        chk1("err_sticky", resp_err, 1'b1);
        c0_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk1("pre_reset_busy", mem_req_valid, 1'b1);
        #1;
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        chk1("arst_mem_valid", mem_req_valid, 1'b0);
        chk1("arst_c0_ready", c0_req_ready, 1'b0);
        chk1("arst_resp_err", resp_err, 1'b0);
        chk1("arst_c0_resp", c0_resp_valid, 1'b0);
        chki("arst_fifo_empty", int'(dut.count_q), 0);
        clear_inputs();
        #1;
        reset = 1'b1;
        model_reset();
        cycle();
        cycle();

        // Randomized traffic against the reference model.
        do_reset();
        for (int t = 0; t < 400; t++) begin
            c0_req_valid       = ($urandom_range(0, 3) != 0);
            c0_req_rw          = ($urandom_range(0, 2) == 0);
            c0_req_data_valid  = ($urandom_range(0, 3) == 0);
            c0_req_addr        = AB'($urandom);
            c0_req_data_bits   = {$urandom, $urandom, $urandom, $urandom};
            c0_req_data_mask   = MB'($urandom);
            c1_req_valid       = ($urandom_range(0, 3) != 0);
            c1_req_rw          = ($urandom_range(0, 2) == 0);
            c1_req_data_valid  = ($urandom_range(0, 3) == 0);
            c1_req_addr        = AB'($urandom);
            c1_req_data_bits   = {$urandom, $urandom, $urandom, $urandom};
            c1_req_data_mask   = MB'($urandom);
            mem_req_ready      = ($urandom_range(0, 3) != 0);
            mem_req_data_ready = ($urandom_range(0, 1) != 0);
            mem_resp_valid     = ($urandom_range(0, 2) == 0);
            mem_resp_data      = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
